pong_ball_ctrl: RTL and testbench
=================================

Name: pong_ball_ctrl

Overview:
Per-frame game sequencer for the pong playfield. It owns ball position and direction, checks wall and paddle collisions against the current paddle positions, keeps both scores, and detects game over. It sits between the paddle-position logic and the object/renderer instances, and replaces the free-running update loop in the top level.

Parameters:
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
BALL_SIZE, 10, ball width and height
PADDLE_W, 10, paddle width
PADDLE_H, 50, paddle height
P1_X, 20, left paddle X (left edge)
P2_X, 620, right paddle X (left edge)
SPEED_X, 2, initial X step per frame (1..15)
SPEED_Y, 2, Y step per frame (1..15)
WIN_SCORE, 9, score that ends the game (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync edge)
serve  in  1  one-cycle pulse: launch ball / restart after game over
p1_y  in  10  left paddle top Y
p2_y  in  10  right paddle top Y
ball_x  out  11  ball left X
ball_y  out  10  ball top Y
score1  out  4  left player score
score2  out  4  right player score
game_over  out  1  high while in S_OVER
busy  out  1  high while a frame update is in progress (S_MOVE..S_SCORE)

Behaviour:
- Reset is sampled on a clk edge while low. Reset values: ball_x=315, ball_y=235, dir_x=1 (right), dir_y=0 (up), speed_x=SPEED_X, score1=score2=0, game_over=0, busy=0, state=S_IDLE. Reset has priority in every state and mid-update.
- States:
  - S_IDLE: ball held at centre. serve -> S_WAIT.
  - S_WAIT: frame_tick -> S_MOVE.
  - S_MOVE: apply X and Y steps.
  - S_WALL: Y bounce.
  - S_PADDLE: paddle hit or miss.
  - S_SCORE: entered only on a miss.
  - S_OVER: game ended.
- Update latency: the new ball_x/ball_y are stable 3 clk after frame_tick (S_MOVE, S_WALL, S_PADDLE), then the FSM returns to S_WAIT. frame_tick while busy=1 is ignored. frame_tick in S_IDLE or S_OVER is ignored.
- Arithmetic uses 12-bit signed intermediates. No wrap-around of ball_x or ball_y is permitted.
- S_MOVE:
  - X: if dir_x=0 and ball_x < speed_x -> ball_x=0, else ball_x -= speed_x. If dir_x=1 and ball_x+speed_x > SCREEN_W-BALL_SIZE -> ball_x = SCREEN_W-BALL_SIZE, else ball_x += speed_x.
  - Y: same clamping, using SPEED_Y and SCREEN_H.
- S_WALL: ball_y==0 -> dir_y=1. ball_y==SCREEN_H-BALL_SIZE -> dir_y=0.
- S_PADDLE, left paddle: vertical overlap means ball_y+BALL_SIZE > p1_y and ball_y < p1_y+PADDLE_H.
  - Hit: dir_x=0, ball_x <= P1_X+PADDLE_W, ball_x+BALL_SIZE > P1_X, and vertical overlap -> ball_x = P1_X+PADDLE_W, dir_x=1.
  - Miss: dir_x=0 and ball_x==0 -> score2+1, goto S_SCORE.
- S_PADDLE, right paddle: mirror of the left, using P2_X and p2_y. Hit -> ball_x = P2_X-BALL_SIZE, dir_x=0. Miss: ball_x==SCREEN_W-BALL_SIZE -> score1+1, goto S_SCORE.
- A wall bounce and a paddle hit in the same frame are both applied (corner hit).
- S_SCORE: ball recentred to (315,235); dir_x points toward the player who conceded; dir_y unchanged; speed_x=SPEED_X.
  - If the incremented score == WIN_SCORE -> S_OVER with game_over=1.
  - Otherwise -> S_IDLE.
  - Scores saturate at 15.
- S_OVER: serve clears both scores and game_over, then -> S_IDLE. The ball stays centred.
- serve in S_WAIT or while busy is ignored. serve and frame_tick in the same cycle in S_IDLE: serve is taken and the tick is dropped.

Optional Feature:
PONG_SPEEDUP_EN:
- Defined: each paddle hit increments speed_x by 1, saturating at 8. speed_x returns to SPEED_X on a point or reset.
- Undefined: speed_x is constant at SPEED_X and the increment logic is absent.

Test Plan:
- Reset low 2 clk -> ball (315,235), scores 0/0, game_over=0, busy=0. serve then 1 frame_tick -> ball (317,233) 3 clk after the tick.
- Ball at y=1, dir_y=0, frame_tick -> ball_y=0 and dir_y=1. The next frame gives ball_y=2.
- Ball at (32,100) moving left, p1_y=80, frame_tick -> ball_x=30, dir_x=1. Next frame ball_x=32.
- Ball at (2,300) moving left, p1_y=0 -> score2=1, ball recentred, FSM in S_IDLE. frame_tick without serve -> no motion.
- score1=8, right miss -> score1=9, game_over=1. frame_tick ignored. serve -> scores 0/0, game_over=0.
- frame_tick pulsed again 1 clk after the first -> ignored (single 2-pixel step). Reset asserted in S_PADDLE -> all reset values on the next clk.

Source files
------------

// File: rtl/pong_ball_ctrl.sv
// Pong ball sequencer: per-frame move, wall bounce, paddle hit/miss, scoring.
// Optional PONG_SPEEDUP_EN: each paddle hit raises speed_x by 1 (max 8).
module pong_ball_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 10,
    parameter int PADDLE_W  = 10,
    parameter int PADDLE_H  = 50,
    parameter int P1_X      = 20,
    parameter int P2_X      = 620,
    parameter int SPEED_X   = 2,
    parameter int SPEED_Y   = 2,
    parameter int WIN_SCORE = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_y,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        game_over,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_MOVE, S_WALL, S_PADDLE, S_SCORE, S_OVER
    } state_t;

    localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] BS     = 12'(BALL_SIZE);
    localparam logic signed [11:0] PH     = 12'(PADDLE_H);
    localparam logic signed [11:0] L_EDGE = 12'(P1_X);
    localparam logic signed [11:0] L_FACE = 12'(P1_X + PADDLE_W);
    localparam logic signed [11:0] R_EDGE = 12'(P2_X);
    localparam logic signed [11:0] R_BACK = 12'(P2_X + PADDLE_W);
    localparam logic signed [11:0] SPY    = 12'(SPEED_Y);
    localparam logic [10:0] X_MID  = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_MID  = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] X_HIT1 = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] X_HIT2 = 11'(P2_X - BALL_SIZE);
    localparam logic [3:0]  SPD0   = 4'(SPEED_X);
    localparam logic [3:0]  WIN    = 4'(WIN_SCORE);

    state_t      state, state_n;
    logic [10:0] ball_x_n;
    logic [9:0]  ball_y_n;
    logic [3:0]  score1_n, score2_n;
    logic [3:0]  speed_x, speed_n;
    logic        dir_x, dir_x_n;
    logic        dir_y, dir_y_n;

    logic signed [11:0] xs, ys, sp, p1s, p2s;
    logic [10:0] x_left, x_right;
    logic [9:0]  y_up, y_down;
    logic        ov1, ov2, hit1, hit2, miss1, miss2;

    function automatic logic [3:0] inc_sat(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

    assign xs  = $signed({1'b0, ball_x});
    assign ys  = $signed({2'b0, ball_y});
    assign sp  = $signed({8'b0, speed_x});
    assign p1s = $signed({2'b0, p1_y});
    assign p2s = $signed({2'b0, p2_y});

    // Steps clamp at the playfield edges so the position never wraps.
    assign x_left  = (xs < sp) ? '0 : 11'(xs - sp);
    assign x_right = (xs + sp > X_MAX) ? 11'(X_MAX) : 11'(xs + sp);
    assign y_up    = (ys < SPY) ? '0 : 10'(ys - SPY);
    assign y_down  = (ys + SPY > Y_MAX) ? 10'(Y_MAX) : 10'(ys + SPY);

    assign ov1   = (ys + BS > p1s) && (ys < p1s + PH);
    assign ov2   = (ys + BS > p2s) && (ys < p2s + PH);
    assign hit1  = !dir_x && (xs <= L_FACE) && (xs + BS > L_EDGE) && ov1;
    assign hit2  = dir_x && (xs + BS >= R_EDGE) && (xs < R_BACK) && ov2;
    assign miss1 = !dir_x && (xs == 12'sd0);
    assign miss2 = dir_x && (xs == X_MAX);

`ifdef PONG_SPEEDUP_EN
    logic [3:0] speed_up;
    assign speed_up = (speed_x < 4'd8) ? speed_x + 4'd1 : speed_x;
`endif

    always_comb begin
        state_n  = state;
        ball_x_n = ball_x;
        ball_y_n = ball_y;
        dir_x_n  = dir_x;
        dir_y_n  = dir_y;
        score1_n = score1;
        score2_n = score2;
        speed_n  = speed_x;
        unique case (state)
            S_IDLE: if (serve) state_n = S_WAIT;
            S_WAIT: if (frame_tick) state_n = S_MOVE;
            S_MOVE: begin
                ball_x_n = dir_x ? x_right : x_left;
                ball_y_n = dir_y ? y_down : y_up;
                state_n  = S_WALL;
            end
            S_WALL: begin
                if (ball_y == '0) dir_y_n = 1'b1;
                else if (ys == Y_MAX) dir_y_n = 1'b0;
                state_n = S_PADDLE;
            end
            S_PADDLE: begin
                state_n = S_WAIT;
                unique case (1'b1)
                    hit1: begin
                        ball_x_n = X_HIT1;
                        dir_x_n  = 1'b1;
`ifdef PONG_SPEEDUP_EN
                        speed_n  = speed_up;
`endif
                    end
                    hit2: begin
                        ball_x_n = X_HIT2;
                        dir_x_n  = 1'b0;
`ifdef PONG_SPEEDUP_EN
                        speed_n  = speed_up;
`endif
                    end
                    miss1: begin
                        score2_n = inc_sat(score2);
                        state_n  = S_SCORE;
                    end
                    miss2: begin
                        score1_n = inc_sat(score1);
                        state_n  = S_SCORE;
                    end
                    default: ;
                endcase
            end
            // dir_x still points at the side that conceded, so it is kept.
            S_SCORE: begin
                ball_x_n = X_MID;
                ball_y_n = Y_MID;
                speed_n  = SPD0;
                if ((dir_x ? score1 : score2) == WIN) state_n = S_OVER;
                else state_n = S_IDLE;
            end
            S_OVER: begin
                if (serve) begin
                    score1_n = '0;
                    score2_n = '0;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            ball_x  <= X_MID;
            ball_y  <= Y_MID;
            dir_x   <= 1'b1;
            dir_y   <= 1'b0;
            score1  <= '0;
            score2  <= '0;
            speed_x <= SPD0;
        end else begin
            state   <= state_n;
            ball_x  <= ball_x_n;
            ball_y  <= ball_y_n;
            dir_x   <= dir_x_n;
            dir_y   <= dir_y_n;
            score1  <= score1_n;
            score2  <= score2_n;
            speed_x <= speed_n;
        end
    end

    assign game_over = (state == S_OVER);
    assign busy      = (state == S_MOVE) || (state == S_WALL) ||
                       (state == S_PADDLE) || (state == S_SCORE);

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: game model scoreboard per frame plus a
// table of hand-derived checkpoints and multi-cycle corner sequences.
module tb_pong_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        serve;
    logic [9:0]  p1_y;
    logic [9:0]  p2_y;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [3:0]  score1;
    logic [3:0]  score2;
    logic        game_over;
    logic        busy;

    pong_ball_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve),
        .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
        .score1(score1), .score2(score2), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [30:0] dut_v;
    assign dut_v = {ball_x, ball_y, score1, score2, game_over, busy};

    int ntests = 0;
    int nfail  = 0;

    // reference game state
    int mx, my, mdx, mdy, ms1, ms2, mover;
    logic [30:0] sb[$];

    typedef struct {
        int serve; int p1t; int p2t; int to_score; int n;
        int ex; int ey; int es1; int es2; int eov;
    } vec_t;
    vec_t tbl[20];

    function automatic logic [30:0] pk(input int x, input int y, input int s1,
                                       input int s2, input int ov, input int bz);
        return {11'(x), 10'(y), 4'(s1), 4'(s2), 1'(ov), 1'(bz)};
    endfunction

    task automatic chk(input string name, input logic [30:0] got,
                       input logic [30:0] want);
        ntests++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got x=%0d y=%0d s1=%0d s2=%0d over=%0d busy=%0d, want x=%0d y=%0d s1=%0d s2=%0d over=%0d busy=%0d",
                     name, got[30:20], got[19:10], got[9:6], got[5:2], got[1], got[0],
                     want[30:20], want[19:10], want[9:6], want[5:2], want[1], want[0]);
        end
    endtask

    function automatic logic [9:0] pad(input bit track, input int y);
        if (track) return (y < 20) ? 10'd0 : 10'(y - 20);
        return (y < 240) ? 10'd400 : 10'd0;
    endfunction

    task automatic model_reset();
        mx = 315; my = 235; mdx = 1; mdy = 0;
        ms1 = 0; ms2 = 0; mover = 0;
    endtask

    task automatic model_frame(input int p1, input int p2, output bit scored);
        scored = 1'b0;
        if (mdx == 0) mx = (mx < 2) ? 0 : mx - 2;
        else          mx = (mx + 2 > 630) ? 630 : mx + 2;
        if (mdy == 0) my = (my < 2) ? 0 : my - 2;
        else          my = (my + 2 > 470) ? 470 : my + 2;
        if (my == 0) mdy = 1;
        else if (my == 470) mdy = 0;
        if (mdx == 0) begin
            if (mx <= 30 && mx + 10 > 20 && my + 10 > p1 && my < p1 + 50) begin
                mx = 30; mdx = 1;
            end else if (mx == 0) begin
                ms2 = (ms2 == 15) ? 15 : ms2 + 1; scored = 1'b1;
            end
        end else begin
            if (mx + 10 >= 620 && mx < 630 && my + 10 > p2 && my < p2 + 50) begin
                mx = 610; mdx = 0;
            end else if (mx == 630) begin
                ms1 = (ms1 == 15) ? 15 : ms1 + 1; scored = 1'b1;
            end
        end
        if (scored) begin
            mover = ((mdx != 0) ? ms1 : ms2) == 9 ? 1 : 0;
            mx = 315; my = 235;
        end
    endtask

    // One frame from S_WAIT; caller is at a negedge.
    task automatic do_frame(input bit p1t, input bit p2t, input bit dbl,
                            output bit scored);
        p1_y = pad(p1t, my);
        p2_y = pad(p2t, my);
        model_frame(int'(p1_y), int'(p2_y), scored);
        sb.push_back(pk(mx, my, ms1, ms2, mover, 0));
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = dbl;
        @(negedge clk);
        frame_tick = 1'b0;
        if (dbl) chk("busy_mid", dut_v, sb[0] | 31'd1);
        repeat (2) @(negedge clk);
        if (scored) @(negedge clk);
        chk("frame", dut_v, sb.pop_front());
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        bit   sc;
        int   k;
        v  = tbl[i];
        sc = 1'b0;
        k  = 0;
        if (v.serve != 0) begin
            serve = 1'b1;
            @(negedge clk);
            serve = 1'b0;
        end
        while (k < v.n && !(v.to_score != 0 && sc)) begin
            do_frame(v.p1t != 0, v.p2t != 0, 1'b0, sc);
            k++;
        end
        if (v.to_score != 0 && !sc) begin
            ntests++;
            nfail++;
            $display("FAIL vec%0d: no point within %0d frames", i, v.n);
        end
        chk($sformatf("vec%0d", i), dut_v,
            pk(v.ex, v.ey, v.es1, v.es2, v.eov, 0));
    endtask

    task automatic idle_tick(input string name, input logic [30:0] want);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        chk(name, dut_v, want);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit sc;
        tbl[0]  = '{0, 0, 0, 0, 116, 549,   1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0,   1, 551,   0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0,   1, 553,   2, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0,  29, 610,  60, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 289,  32, 302, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0,   1,  30, 300, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0,   1,  32, 298, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 400, 315, 235, 1, 0, 0};
        tbl[8]  = '{1, 0, 1, 1, 600, 315, 235, 1, 1, 0};
        tbl[9]  = '{1, 1, 0, 1, 600, 315, 235, 2, 1, 0};
        tbl[10] = '{1, 0, 0, 0,   1, 317, 233, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 400, 315, 235, 1, 0, 0};
        for (int k = 2; k <= 9; k++)
            tbl[10 + k] = '{1, 0, 0, 1, 400, 315, 235, k, 0, (k == 9) ? 1 : 0};

        reset = 1'b0; frame_tick = 1'b0; serve = 1'b0;
        p1_y = 10'd0; p2_y = 10'd0;
        repeat (2) @(negedge clk);
        chk("reset", dut_v, pk(315, 235, 0, 0, 0, 0));
        reset = 1'b1;
        model_reset();

        // serve and tick together: tick is dropped
        serve = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        serve = 1'b0; frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        chk("serve_tick_same", dut_v, pk(315, 235, 0, 0, 0, 0));

        // second tick one clk after the first is ignored
        do_frame(1'b0, 1'b0, 1'b1, sc);
        repeat (4) @(negedge clk);
        chk("dbl_tick", dut_v, pk(317, 233, 0, 0, 0, 0));

        for (int i = 0; i <= 7; i++) run_vec(i);
        idle_tick("idle_tick", pk(315, 235, 1, 0, 0, 0));
        for (int i = 8; i <= 9; i++) run_vec(i);

        // reset while in S_PADDLE
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid", dut_v, pk(315, 235, 0, 0, 0, 0));
        reset = 1'b1;
        model_reset();

        for (int i = 10; i <= 19; i++) run_vec(i);
        idle_tick("over_tick", pk(315, 235, 9, 0, 1, 0));
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        @(negedge clk);
        chk("over_serve", dut_v, pk(315, 235, 0, 0, 0, 0));
        idle_tick("after_clear", pk(315, 235, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
